conv1_w_loader: RTL
===================

# conv1_w_loader

Conv-layer-1 weight prefetch stage. It sits directly downstream of the conv1 weight ROM (32×48-bit, one registered read port, 1-cycle read latency). On a start pulse it walks ROM addresses 0..24, captures the six 8-bit kernel weights returned for each address, and holds all 6×25 weights in registers. The conv1 PE array reads them as one flat bus, qualified by `done`.

## Interface

**Parameters**

- `TAPS` — default 25 — taps per kernel (5×5); ROM addresses 0..TAPS-1 are fetched.
- `NK` — default 6 — number of kernels, i.e. byte lanes per ROM word.
- `DW` — default 8 — weight width.
- `AW` — default 5 — ROM address width.

**Ports**

- `clk` — in — 1 — single clock, rising edge.
- `rst_n` — in — 1 — asynchronous, active-low reset.
- `start` — in — 1 — one-cycle load request; honoured only when not busy.
- `w1_raddr` — out — AW — ROM address, driven from a register.
- `w1_1_rdata` .. `w1_6_rdata` — in — DW each — ROM lanes for kernels 1..6; valid one cycle after the address is sampled.
- `busy` — out — 1 — fetch in progress.
- `done` — out — 1 — sticky; all NK×TAPS weights are valid.
- `w1_kernel` — out — NK*TAPS*DW — weight bus. Kernel k (0-based, lane k+1), tap t is at bits [(k*TAPS+t)*DW +: DW].

## Operation

**States**

- IDLE
  - `start`=1 → FETCH.
  - At that transition: tap counter ← 0, `w1_raddr` ← 0, `busy` ← 1, `done` ← 0.
- FETCH
  - Each cycle: `w1_raddr` ← `w1_raddr`+1, until it holds TAPS-1.
  - Next cycle → DRAIN, with `w1_raddr` ← 0.
- DRAIN
  - One cycle; captures the data for address TAPS-1.
  - → IDLE, with `busy` ← 0 and `done` ← 1.

**Capture pipeline**

- A delayed valid/index pair (`cap_vld`, `cap_idx`) tracks each issued address by 2 edges: 1 edge for the ROM read, 1 edge for capture.
- On capture, lane k is written to kernel k, tap `cap_idx`, for all k in the same edge.
- Weights are stored raw. No sign extension or arithmetic is applied.

**Boundary conditions**

- `start` while `busy`: ignored. No restart, no counter disturbance.
- `start` while `done`=1 (reload): `done` clears on the next edge. Taps are overwritten in index order; untouched taps keep their old values until overwritten. `done` reasserts only after the full reload.
- `w1_raddr` never exceeds TAPS-1. ROM addresses TAPS..31 are never read.
- `start` held high continuously: one load per IDLE visit. A new load begins on the edge after `done` rises.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). No partial `done`.

**Reset values**

- State = IDLE.
- `w1_raddr` = 0, `busy` = 0, `done` = 0.
- `w1_kernel` = all zeros.
- `cap_vld` = 0.

## Timing

Edge E0 samples `start`=1 in IDLE.

- After E0: `busy`=1, `w1_raddr`=0.
- After Ei (i=0..24): `w1_raddr`=i.
- ROM data for address i is valid after E(i+1). It is captured into tap i at E(i+2).
- Last capture is at E26.
  - `busy` falls after E26 (it is high for exactly 26 cycles).
  - `done` rises after E26, in the same edge as the last capture, so `w1_kernel` is complete whenever `done`=1.
- Latency: `start` sampled → `done` high = 26 cycles.
- Back-to-back loads: next `start` sampled at E26 or later.
- `w1_raddr` returns to 0 after E25 and holds 0 in IDLE.

## Test plan

1. **Reset:** assert `rst_n`=0 mid-simulation → `busy`=0, `done`=0, `w1_raddr`=0, `w1_kernel`=0, all within the same cycle (asynchronous).
2. **Full load:** ROM model returns lane k = {k[2:0], addr[4:0]} with 1-cycle latency; pulse `start` → `w1_raddr` steps 0..24 on consecutive cycles, `done` rises exactly 26 cycles after `start`, and all 150 bytes match, e.g. kernel 3 tap 17 = 8'h71.
3. **Busy start:** pulse `start` again at E5 and E20 of a load → address sequence unbroken, `done` still at E26, data identical to scenario 2.
4. **Reload:** after `done`, change the ROM pattern to the bitwise inverse and pulse `start` → `done` drops next cycle and rises 26 cycles later; all taps equal the inverted pattern.
5. **Mid-fetch reset:** assert reset when `w1_raddr`=10, release, then start → clean full load; `done` exactly 26 cycles after the new `start`, with no stale `done` pulse.
6. **Address bound:** monitor `w1_raddr` throughout scenarios 2–5 → never >24; 0 whenever `busy`=0.

Source files
------------

// File: rtl/conv1_w_loader.sv
// Conv1 weight prefetch: walks the weight ROM once per start request and holds
// all NK x TAPS kernel weights on a flat register bus for the PE array.
module conv1_w_loader #(
    parameter int TAPS = 25,
    parameter int NK   = 6,
    parameter int DW   = 8,
    parameter int AW   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [AW-1:0]           w1_raddr,
    input  logic [DW-1:0]           w1_1_rdata,
    input  logic [DW-1:0]           w1_2_rdata,
    input  logic [DW-1:0]           w1_3_rdata,
    input  logic [DW-1:0]           w1_4_rdata,
    input  logic [DW-1:0]           w1_5_rdata,
    input  logic [DW-1:0]           w1_6_rdata,
    output logic                    busy,
    output logic                    done,
    output logic [NK*TAPS*DW-1:0]   w1_kernel
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] raddr_nxt;
    logic          busy_nxt;
    logic          done_nxt;
    logic          cap_vld;
    logic [AW-1:0] cap_idx;
    logic [DW-1:0] lane [6];

    assign lane[0] = w1_1_rdata;
    assign lane[1] = w1_2_rdata;
    assign lane[2] = w1_3_rdata;
    assign lane[3] = w1_4_rdata;
    assign lane[4] = w1_5_rdata;
    assign lane[5] = w1_6_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            w1_raddr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            w1_raddr <= raddr_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (w1_raddr == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // start is only looked at in IDLE, so requests during a fetch are dropped
    always_comb begin
        raddr_nxt = w1_raddr;
        busy_nxt  = busy;
        done_nxt  = done;
        case (state)
            IDLE: begin
                if (start) begin
                    raddr_nxt = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                end
            end
            FETCH: begin
                raddr_nxt = (w1_raddr == LAST) ? '0 : w1_raddr + AW'(1);
            end
            DRAIN: begin
                busy_nxt = 1'b0;
                done_nxt = 1'b1;
            end
            default: begin
                raddr_nxt = '0;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // ROM read stage -> capture stage: cap_vld/cap_idx mark the address the
    // ROM is returning now; the last capture lands on the same edge done rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld   <= 1'b0;
            cap_idx   <= '0;
            w1_kernel <= '0;
        end else begin
            cap_vld <= (state == FETCH);
            cap_idx <= w1_raddr;
            if (cap_vld) begin
                for (int k = 0; k < NK; k++) begin
                    w1_kernel[(k*TAPS + int'(cap_idx))*DW +: DW] <= lane[k];
                end
            end
        end
    end

endmodule
